// File: rtl/inv_arb_pkg.sv
// Shared definitions for the serial inverter arbiter: FSM state encoding,
// default sizing constants and a small sizing helper.
package inv_arb_pkg;

    // Default number of requesters and word width.
    localparam int DEFAULT_N_REQ = 4;
    localparam int DEFAULT_WIDTH = 8;

    // State encodings kept as plain constants so older code that compares
    // raw state bits keeps working; the enum below is built from them.
    localparam logic [1:0] STATE_IDLE  = 2'd0;
    localparam logic [1:0] STATE_SHIFT = 2'd1;
    localparam logic [1:0] STATE_DONE  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = STATE_IDLE,
        SHIFT = STATE_SHIFT,
        DONE  = STATE_DONE
    } arbStateT;

    // Width of a counter that must reach w-1; never narrower than one bit
    // so a 1-bit word still gets a legal counter.
    function automatic int cntWidth(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/bit_inverter.sv
// Single-bit combinational inverter. This is the shared resource that the
// arbiter time-multiplexes between requesters, one bit per clock.
module bit_inverter (
    input  logic bitIn,
    output logic bitOut
);

    assign bitOut = ~bitIn;

endmodule

// File: rtl/serial_inverter_arbiter.sv
// Round-robin arbiter in front of one shared 1-bit inverter. A granted word
// is streamed LSB-first through the inverter, collected MSB-in into a shift
// register, and returned complemented together with the requester id.
module serial_inverter_arbiter
    import inv_arb_pkg::*;
#(
    parameter int N_REQ = DEFAULT_N_REQ,
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic [N_REQ-1:0]       ReqValid,
    input  logic [N_REQ*WIDTH-1:0] ReqData,
    output logic [N_REQ-1:0]       ReqReady,
    output logic                   RespValid,
    output logic [ID_W-1:0]        RespId,
    output logic [WIDTH-1:0]       RespData,
    output logic                   Busy
);

    localparam int              CNT_W    = cntWidth(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(N_REQ - 1);

    // Round-robin search: first set bit of valid starting just above last,
    // wrapping modulo N_REQ. Returns {found, index}. Walking the offsets from
    // farthest to nearest lets the nearest candidate win the final write.
    function automatic logic [ID_W:0] pickNext(
        input logic [N_REQ-1:0] valid,
        input logic [ID_W-1:0]  last
    );
        logic [ID_W:0] result;
        int            cand;
        result = '0;
        for (int step = N_REQ; step >= 1; step--) begin
            cand = (int'(last) + step) % N_REQ;
            if (valid[cand]) begin
                result = {1'b1, ID_W'(cand)};
            end
        end
        return result;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    arbStateT         stateReg;
    logic [ID_W-1:0]  lastGrantReg;
    logic [ID_W-1:0]  curIdReg;
    logic [CNT_W-1:0] bitCntReg;
    logic [WIDTH-1:0] shiftInReg;
    logic [WIDTH-1:0] shiftOutReg;
    logic             respValidReg;
    logic [ID_W-1:0]  respIdReg;
    logic [WIDTH-1:0] respHoldReg;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic [ID_W:0]    pick;
    logic             grantFound;
    logic [ID_W-1:0]  grantId;
    logic [N_REQ-1:0] grantSel;
    logic             acceptNow;
    logic [WIDTH-1:0] reqWord [N_REQ];
    logic [WIDTH-1:0] grantedWord;

    assign pick       = pickNext(ReqValid, lastGrantReg);
    assign grantFound = pick[ID_W];
    assign grantId    = pick[ID_W-1:0];

    // Reset is checked here as well because the state register is already
    // IDLE while reset is held, and no grant may leak out in that window.
    assign acceptNow  = (stateReg == IDLE) && grantFound && !Reset;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
            assign reqWord[gi]  = ReqData[gi*WIDTH +: WIDTH];
            assign grantSel[gi] = grantFound && (grantId == ID_W'(gi));
            assign ReqReady[gi] = acceptNow && grantSel[gi];
        end
    endgenerate

    // One-hot AND-OR mux picking the granted requester's word.
    always_comb begin
        grantedWord = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grantSel[i]) begin
                grantedWord = grantedWord | reqWord[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Shared inverter and shift paths
    // ------------------------------------------------------------------
    logic             invIn;
    logic             invOut;
    logic [WIDTH-1:0] shiftInNext;
    logic [WIDTH-1:0] shiftOutNext;

    assign invIn       = shiftInReg[0];
    assign shiftInNext = shiftInReg >> 1;

    bit_inverter u_inverter (
        .bitIn  (invIn),
        .bitOut (invOut)
    );

    generate
        if (WIDTH == 1) begin : g_out_narrow
            assign shiftOutNext = invOut;
        end else begin : g_out_wide
            assign shiftOutNext = {invOut, shiftOutReg[WIDTH-1:1]};
        end
    endgenerate

    // FSM: grant in IDLE, count WIDTH bit-times in SHIFT, one response cycle in DONE.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            stateReg     <= IDLE;
            lastGrantReg <= LAST_ID;
            curIdReg     <= '0;
            bitCntReg    <= '0;
        end else begin
            unique case (stateReg)
                IDLE: begin
                    if (grantFound) begin
                        curIdReg     <= grantId;
                        lastGrantReg <= grantId;
                        bitCntReg    <= '0;
                        stateReg     <= SHIFT;
                    end
                end
                SHIFT: begin
                    bitCntReg <= bitCntReg + CNT_W'(1);
                    if (bitCntReg == LAST_BIT) begin
                        stateReg <= DONE;
                    end
                end
                DONE: begin
                    stateReg <= IDLE;
                end
                default: begin
                    stateReg <= IDLE;
                end
            endcase
        end
    end

    // Datapath: load the granted word, then stream it through the inverter.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            shiftInReg  <= '0;
            shiftOutReg <= '0;
        end else begin
            if (stateReg == IDLE && grantFound) begin
                shiftInReg <= grantedWord;
            end else if (stateReg == SHIFT) begin
                shiftInReg  <= shiftInNext;
                shiftOutReg <= shiftOutNext;
            end
        end
    end

    // Response side: pulse valid for the DONE cycle and keep the last id and
    // data visible until the next response replaces them.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            respValidReg <= 1'b0;
            respIdReg    <= '0;
            respHoldReg  <= '0;
        end else begin
            respValidReg <= 1'b0;
            if (stateReg == SHIFT && bitCntReg == LAST_BIT) begin
                respValidReg <= 1'b1;
                respIdReg    <= curIdReg;
            end
            if (stateReg == DONE) begin
                respHoldReg <= shiftOutReg;
            end
        end
    end

    // During DONE the finished shift register is shown directly; afterwards
    // the held copy keeps the value stable while the next word shifts.
    assign RespData  = (stateReg == DONE) ? shiftOutReg : respHoldReg;
    assign RespValid = respValidReg;
    assign RespId    = respIdReg;
    assign Busy      = (stateReg != IDLE);

endmodule

// File: doc/serial_inverter_arbiter.md
# serial_inverter_arbiter

Shares one 1-bit inverter stage between `N_REQ` requesters. Each requester submits a `WIDTH`-bit word. The block grants requesters round-robin, streams the granted word LSB-first through the single inverter one bit per clock, then returns the complemented word with the requester's id. It sits between the requesting units and the shared inversion resource, and it is the only agent that drives that resource.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters, ≥2.
- `WIDTH`, default 8: word width in bits, ≥1.
- `ID_W`, default `$clog2(N_REQ)`: width of requester id. Derived; do not override.

Ports:
- `Clock`  in  1  sole clock, rising edge.
- `Reset`  in  1  asynchronous, active-high.
- `ReqValid`  in  `N_REQ`  bit i: requester i holds a word on `ReqData`.
- `ReqData`  in  `N_REQ*WIDTH`  word i occupies bits `[i*WIDTH +: WIDTH]`.
- `ReqReady`  out  `N_REQ`  one-hot. Bit i is high in the cycle word i is accepted.
- `RespValid`  out  1  one-cycle pulse. The result is valid in that cycle.
- `RespId`  out  `ID_W`  requester whose result is on `RespData`.
- `RespData`  out  `WIDTH`  bitwise complement of the accepted word.
- `Busy`  out  1  high while in SHIFT or DONE.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - If any `ReqValid` is set, grant the first set bit searching from `LastGrant+1` upward, wrapping modulo `N_REQ`.
  - `ReqReady[g]` is combinational in this cycle.
  - At the clock edge: latch word g into `ShiftIn`, set `CurId=g`, `LastGrant=g`, `BitCnt=0`, and go to SHIFT.
  - If no request is present, stay in IDLE with `ReqReady=0`.
- SHIFT:
  - Each cycle, `ShiftIn[0]` drives the inverter input.
  - The inverter output shifts into `ShiftOut` at the MSB, and `ShiftIn` shifts right.
  - `BitCnt` increments each cycle. When `BitCnt==WIDTH-1` the FSM goes to DONE.
  - After WIDTH cycles, `ShiftOut[i] = ~word[i]`.
- DONE:
  - `RespValid=1`, `RespData=ShiftOut`, `RespId=CurId` (registered outputs).
  - Go to IDLE at the next edge.
- `ReqReady` is 0 in SHIFT and DONE. Requests arriving then wait.
- Requesters hold `ReqValid` and `ReqData` until they see `ReqReady`.
- `ReqData` changes after acceptance have no effect.
- A `ReqValid` dropped before it is granted is simply not served; no error.
- `RespData` and `RespId` hold their last values between pulses.
- `Busy` = (state != IDLE).
- No backpressure on the response side. The consumer must take `RespValid` in the cycle it is asserted.

## Timing
- Accept edge at end of cycle 0. SHIFT occupies cycles 1..WIDTH. `RespValid` is high in cycle WIDTH+1. The earliest next accept is cycle WIDTH+2.
- Latency is WIDTH+1 cycles from the accept edge. Throughput is one word per WIDTH+2 cycles.
- Reset asserted, at any time, including mid-SHIFT:
  - State forces to IDLE and `LastGrant` to `N_REQ-1`, so requester 0 has first priority.
  - `BitCnt`, `ShiftIn`, `ShiftOut`, `RespData`, and `RespId` clear to 0.
  - `RespValid` and `Busy` clear to 0.
  - `ReqReady` is forced to 0 while `Reset` is high.
  - The in-flight word is discarded and no response is issued.
- After `Reset` deasserts, the first IDLE cycle may accept immediately.
- Simultaneous requests: exactly one grant per IDLE cycle. The round-robin rotation guarantees that each requester holding `ReqValid` is served within `N_REQ` grants.
- Wrap-around: when `LastGrant=N_REQ-1`, the search starts at 0.

## Structure
- Package `inv_arb_pkg`: state enum (IDLE, SHIFT, DONE) and default parameter constants.
- Sub-module `bit_inverter`: 1-bit combinational inverter, instantiated exactly once as the shared resource.
- The arbiter priority search lives in the top module as a function. No separate arbiter module.

## Test plan
- **Single request:** after reset, `ReqValid=4'b0001`, word0=0xA5. Expect `ReqReady=4'b0001` in cycle 0, then `RespValid` in cycle 9 with `RespData=0x5A`, `RespId=0`, and `Busy` high in cycles 1-9.
- **Extremes:** word 0x00 gives 0xFF, and word 0xFF gives 0x00, each with id intact.
- **Full contention:** all four `ReqValid` held high with distinct words. Expect grant order 0,1,2,3,0 with accepts spaced 10 cycles apart, and each `RespData` equal to the complement of its own word.
- **Non-zero first grant:** after reset, only `ReqValid[2]` is set. It is accepted in the first IDLE cycle. Then assert 0 and 3 together: 3 is granted before 0.
- **Reset mid-operation:** assert `Reset` in cycle 4 of SHIFT. All outputs go to 0 immediately and no `RespValid` appears. The held request is re-accepted in the first cycle after release, and the full result is correct.
- **Withdrawn request:** `ReqValid[1]` pulses during SHIFT and drops before IDLE. It never receives `ReqReady` and never produces a response.
